// File: rtl/ssd_bcd_scanner.sv
// Binary-to-BCD converter (serial double-dabble) driving a multiplexed seven-segment display.
// Optional leading-zero blanking: define SSD_LZ_BLANK_EN.
module ssd_bcd_scanner #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BIN_W      = 8,
  parameter int unsigned SCAN_DIV_W = 18
) (
  input  logic                    board_clk,
  input  logic                    Reset,
  input  logic                    load,
  input  logic [BIN_W-1:0]        bin_in,
  output logic                    busy,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    overflow,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              cathodes
);

  localparam int unsigned OUT_W      = 4 * NUM_DIGITS;
  // 0.31 > log10(2), so this digit count always covers 2^BIN_W - 1
  localparam int unsigned BIN_DIGITS = (BIN_W * 31) / 100 + 1;
  localparam int unsigned BCD_DIGITS = ((BIN_DIGITS > NUM_DIGITS) ? BIN_DIGITS : NUM_DIGITS) + 1;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
  localparam int unsigned CNT_W      = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIN_W-1:0]      bin_q, bin_d;
  logic [BCD_W-1:0]      sh_q, sh_d;
  logic                  busy_q, busy_d;
  logic [OUT_W-1:0]      bcd_q, bcd_d;
  logic                  ovf_q, ovf_d;
  logic [SCAN_DIV_W-1:0] pre_q, pre_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            cath_q, cath_d;

  logic [BCD_W-1:0]      adj;
  logic [BCD_W:0]        shifted;
  logic [IDX_W+1:0]      nib_base;
  logic [3:0]            nib;
  logic                  blank;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0:    seg7 = 7'b0000001;
      4'h1:    seg7 = 7'b1001111;
      4'h2:    seg7 = 7'b0010010;
      4'h3:    seg7 = 7'b0000110;
      4'h4:    seg7 = 7'b1001100;
      4'h5:    seg7 = 7'b0100100;
      4'h6:    seg7 = 7'b0100000;
      4'h7:    seg7 = 7'b0001111;
      4'h8:    seg7 = 7'b0000000;
      4'h9:    seg7 = 7'b0000100;
      4'hA:    seg7 = 7'b0001000;
      4'hB:    seg7 = 7'b1100000;
      4'hC:    seg7 = 7'b0110001;
      4'hD:    seg7 = 7'b1000010;
      4'hE:    seg7 = 7'b0110000;
      default: seg7 = 7'b0111000;
    endcase
  endfunction

  // Conversion FSM; the result commits on the last shift so bcd_out never shows partial sums
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;

    adj = sh_q;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (sh_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = sh_q[4*i +: 4] + 4'd3;
    end
    shifted = {adj, bin_q[BIN_W-1]};

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (load) begin
          state_d = S_SHIFT;
          bin_d   = bin_in;
          sh_d    = '0;
          cnt_d   = '0;
        end
      end
      S_SHIFT: begin
        sh_d  = shifted[BCD_W-1:0];
        bin_d = bin_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = S_DONE;
          bcd_d   = shifted[OUT_W-1:0];
          ovf_d   = |shifted[BCD_W:OUT_W];
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_SHIFT);

    // Free-running digit scan, decoded from next-state values so anodes and index stay aligned
    pre_d = pre_q + SCAN_DIV_W'(1);
    idx_d = idx_q;
    if (pre_q == '1) idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);

    nib_base = {idx_d, 2'b00};
    nib      = 4'(bcd_d >> nib_base);
`ifdef SSD_LZ_BLANK_EN
    blank = (idx_d != '0) && ((bcd_d >> nib_base) == '0) && !ovf_d;
`else
    blank = 1'b0;
`endif
    an_d   = blank ? '1 : ~(NUM_DIGITS'(1) << idx_d);
    cath_d = ovf_d ? 8'b11111101 : {seg7(nib), 1'b1};
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      sh_q    <= '0;
      busy_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      pre_q   <= '0;
      idx_q   <= '0;
      an_q    <= ~NUM_DIGITS'(1);
      cath_q  <= 8'b00000011;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      sh_q    <= sh_d;
      busy_q  <= busy_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      cath_q  <= cath_d;
    end
  end

  assign busy     = busy_q;
  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;
  assign an       = an_q;
  assign cathodes = cath_q;

endmodule
